// File: rtl/rom_fetch_streamer.sv
// rom_fetch_streamer: credit-based ROM read initiator feeding a 2-entry valid/ready output buffer
module rom_fetch_streamer #(
  parameter int DATA_WIDTH = 13,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           rom_addr_o,
  output logic                  rom_rden_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
  state_t                 state_q, state_d;
  logic [31:0]            base_q, base_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, issued_q, issued_d;
  logic                   done_q, done_d;
  logic                   inflight_q, inflight_last_q;
  logic [1:0]             occ_q;
  logic [DATA_WIDTH-1:0]  data0_q, data1_q;
  logic                   last0_q, last1_q;
  logic                   pop, issue;
  assign pop        = (occ_q != 2'd0) && m_ready_i;
  assign issue      = (state_q == FETCH) && ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign busy_o     = state_q != IDLE;
  assign done_o     = done_q;
  assign rom_rden_o = issue;
  assign rom_addr_o = issue ? base_q + 32'(issued_q) : '0;
  assign m_valid_o  = occ_q != 2'd0;
  assign m_data_o   = data0_q;
  assign m_last_o   = m_valid_o && last0_q;
  // next-state: command latch, issue counting, completion on final handshake
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && length_i != '0) begin
          base_d   = base_addr_i;
          len_d    = length_i;
          issued_d = '0;
          state_d  = FETCH;
        end else if (start_i) begin
          done_d = 1'b1;
        end
      end
      FETCH: begin
        if (issue) begin
          issued_d = issued_q + ONE;
          state_d  = (issued_d == len_q) ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if (pop && last0_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // control registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end
  // in-flight tracking and 2-entry output FIFO; ROM data captured only the cycle after a read
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (issued_q == len_q - ONE);
      if (inflight_q && pop) begin
        if (occ_q == 2'd1) begin
          data0_q <= rom_data_i;
          last0_q <= inflight_last_q;
        end else begin
          data0_q <= data1_q;
          last0_q <= last1_q;
          data1_q <= rom_data_i;
          last1_q <= inflight_last_q;
        end
      end else if (pop) begin
        data0_q <= data1_q;
        last0_q <= last1_q;
        occ_q   <= occ_q - 2'd1;
      end else if (inflight_q) begin
        if (occ_q == 2'd0) begin
          data0_q <= rom_data_i;
          last0_q <= inflight_last_q;
        end else begin
          data1_q <= rom_data_i;
          last1_q <= inflight_last_q;
        end
        occ_q <= occ_q + 2'd1;
      end
    end
  end
endmodule
